run_req_initiator: RTL and testbench

//  Hardware-side caller for generated method blocks using the i_run_req / o_run_busy run protocol.
//  On i_start it issues a one-cycle run request to a callee and waits for the callee's busy to rise, then fall.
//  It reports completion, elapsed cycle count and a start-timeout flag.

---
 rtl/run_ctrl_pkg.sv | 20 ++
 rtl/sat_counter.sv | 29 ++
 rtl/run_req_initiator.sv | 121 ++++++++++++
 tb/tb_run_req_initiator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the i_run_req / o_run_busy run protocol.
// Used by the run_req initiator and, later, by a run_req responder wrapper.
package run_ctrl_pkg;

   localparam int RUN_STATE_W = 3;

   typedef enum logic [RUN_STATE_W-1:0] {
      IDLE      = 3'd0,
      REQ       = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      DONE      = 3'd4
   } run_state_t;

   // True in the states where a run is in flight and elapsed time accrues.
   function automatic logic run_active(input run_state_t s);
      return (s == REQ) || (s == WAIT_BUSY) || (s == WAIT_DONE);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
// Everything holds while ce is low.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         ce,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] Q_MAX = '1;

   // Clear has priority over increment; increment stops at Q_MAX.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (ce) begin
         if (clr) begin
            q <= '0;
         end else if (inc && (q != Q_MAX)) begin
            q <= q + W'(1);
         end
      end
   end

endmodule

// File: rtl/run_req_initiator.sv
// Hardware caller for blocks speaking the run_req / run_busy protocol.
// Issues a one-cycle run request, waits for the callee's busy to rise and
// fall, then reports completion, elapsed cycles and a start-timeout flag.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for i_start; counters cleared on acceptance
//   REQ       | o_run_req high for exactly this cycle
//   WAIT_BUSY | waiting for callee busy to rise; start timeout runs here
//   WAIT_DONE | callee busy; waiting for it to fall
//   DONE      | o_done pulse, o_cycles / o_timeout freshly latched
module run_req_initiator #(
   parameter int CNT_W         = 32,
   parameter int START_TIMEOUT = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ce,
   input  logic             i_start,
   output logic             o_run_req,
   input  logic             i_run_busy,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_timeout,
   output logic [CNT_W-1:0] o_cycles
);

   import run_ctrl_pkg::*;

   localparam int                WAIT_W    = $clog2(START_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   run_state_t        state;
   logic [CNT_W-1:0]  elapsed_q;
   logic [CNT_W-1:0]  cycles_final;
   logic [WAIT_W-1:0] wait_q;
   logic              start_accept;
   logic              elapsed_inc;
   logic              wait_inc;

   assign start_accept = (state == IDLE) && i_start;
   assign elapsed_inc  = run_active(state);
   assign wait_inc     = (state == WAIT_BUSY) && !i_run_busy;

   // The elapsed counter still counts the cycle that moves us into DONE, so
   // the latched value is one past the current count (saturated).
   assign cycles_final = (elapsed_q == CNT_MAX) ? CNT_MAX : elapsed_q + CNT_W'(1);

   sat_counter #(.W(CNT_W)) u_elapsed (
      .clock   (clock),
      .reset_n (reset_n),
      .ce      (ce),
      .clr     (start_accept),
      .inc     (elapsed_inc),
      .q       (elapsed_q)
   );

   sat_counter #(.W(WAIT_W)) u_wait (
      .clock   (clock),
      .reset_n (reset_n),
      .ce      (ce),
      .clr     (start_accept),
      .inc     (wait_inc),
      .q       (wait_q)
   );

   // Run sequencing with registered outputs that change together with state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         o_run_req <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_timeout <= 1'b0;
         o_cycles  <= '0;
      end else if (ce) begin
         o_run_req <= 1'b0;
         o_done    <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  state     <= REQ;
                  o_run_req <= 1'b1;
                  o_busy    <= 1'b1;
               end
            end
            REQ: begin
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (i_run_busy) begin
                  state <= WAIT_DONE;
               end else if (wait_q == WAIT_LAST) begin
                  state     <= DONE;
                  o_done    <= 1'b1;
                  o_timeout <= 1'b1;
                  o_cycles  <= cycles_final;
               end
            end
            WAIT_DONE: begin
               if (!i_run_busy) begin
                  state     <= DONE;
                  o_done    <= 1'b1;
                  o_timeout <= 1'b0;
                  o_cycles  <= cycles_final;
               end
            end
            DONE: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_run_req_initiator.sv
// Directed bench for run_req_initiator. The callee is played by the stimulus
// sequence itself. A second instance with a 4-bit counter shares all inputs
// to exercise saturation.
module tb_run_req_initiator;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        ce;
   logic        i_start;
   logic        i_run_busy;
   logic        o_run_req;
   logic        o_busy;
   logic        o_done;
   logic        o_timeout;
   logic [31:0] o_cycles;
   logic        r4_run_req;
   logic        r4_busy;
   logic        r4_done;
   logic        r4_timeout;
   logic [3:0]  r4_cycles;

   int n_asserts = 0;
   int n_fail    = 0;
   int req_cnt   = 0;
   int done_cnt  = 0;
   int n_wait;

   run_req_initiator #(.CNT_W(32), .START_TIMEOUT(16)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .ce         (ce),
      .i_start    (i_start),
      .o_run_req  (o_run_req),
      .i_run_busy (i_run_busy),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_timeout  (o_timeout),
      .o_cycles   (o_cycles)
   );

   run_req_initiator #(.CNT_W(4), .START_TIMEOUT(16)) dut4 (
      .clock      (clock),
      .reset_n    (reset_n),
      .ce         (ce),
      .i_start    (i_start),
      .o_run_req  (r4_run_req),
      .i_run_busy (i_run_busy),
      .o_busy     (r4_busy),
      .o_done     (r4_done),
      .o_timeout  (r4_timeout),
      .o_cycles   (r4_cycles)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "simulation did not finish");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample 1 ns after the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
      if (o_run_req === 1'b1) req_cnt++;
      if (o_done === 1'b1) done_cnt++;
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      while (o_done !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      ce         = 1'b1;
      i_start    = 1'b0;
      i_run_busy = 1'b0;
      repeat (3) tick();
      check("rst_run_req", o_run_req, 0);
      check("rst_busy",    o_busy,    0);
      check("rst_done",    o_done,    0);
      check("rst_timeout", o_timeout, 0);
      check("rst_cycles",  o_cycles,  0);
      check("rst_busy4",   r4_busy,   0);
      reset_n = 1'b1;
      tick();

      // 1: busy one cycle after req, held 5 cycles
      req_cnt = 0; done_cnt = 0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("t1_req_hi",   o_run_req,  1);
      check("t1_req_hi4",  r4_run_req, 1);
      check("t1_busy",     o_busy,     1);
      tick();
      check("t1_req_lo",   o_run_req,  0);
      i_run_busy = 1'b1;
      repeat (5) tick();
      i_run_busy = 1'b0;
      check("t1_no_early_done", o_done, 0);
      wait_done(20, n_wait);
      check("t1_done",     o_done,    1);
      check("t1_latency",  n_wait,    1);
      check("t1_timeout",  o_timeout, 0);
      check("t1_cycles",   o_cycles,  7);
      check("t1_cycles4",  r4_cycles, 7);
      check("t1_req_cnt",  req_cnt,   1);
      tick();
      check("t1_done_lo",  o_done,    0);
      check("t1_idle",     o_busy,    0);
      check("t1_done_cnt", done_cnt,  1);
      check("t1_hold",     o_cycles,  7);

      // 2: callee never responds
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      wait_done(40, n_wait);
      check("t2_done",     o_done,    1);
      check("t2_latency",  n_wait,    17);
      check("t2_timeout",  o_timeout, 1);
      check("t2_cycles",   o_cycles,  17);
      check("t2_cycles4",  r4_cycles, 15);
      tick();
      check("t2_done_lo",  o_done,    0);

      // 3: start held high, three back-to-back runs with busy length 3
      req_cnt = 0;
      i_start = 1'b1;
      for (int r = 0; r < 3; r++) begin
         tick();
         check("t3_req_hi",  o_run_req, 1);
         tick();
         check("t3_req_lo",  o_run_req, 0);
         i_run_busy = 1'b1;
         repeat (3) tick();
         i_run_busy = 1'b0;
         wait_done(10, n_wait);
         check("t3_latency", n_wait,    1);
         check("t3_cycles",  o_cycles,  5);
         check("t3_timeout", o_timeout, 0);
         tick();
         check("t3_idle",    o_busy,    0);
         if (r == 2) i_start = 1'b0;
      end
      check("t3_req_cnt", req_cnt, 3);
      tick();
      check("t3_stop", o_busy, 0);

      // 4: ce low for 4 cycles in WAIT_DONE
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      i_run_busy = 1'b1;
      repeat (2) tick();
      ce = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t4_frz_busy",   o_busy,    1);
         check("t4_frz_done",   o_done,    0);
         check("t4_frz_req",    o_run_req, 0);
         check("t4_frz_cycles", o_cycles,  5);
      end
      ce = 1'b1;
      repeat (3) tick();
      i_run_busy = 1'b0;
      wait_done(10, n_wait);
      check("t4_latency", n_wait,    1);
      check("t4_cycles",  o_cycles,  7);
      check("t4_timeout", o_timeout, 0);
      tick();

      // 5: reset in WAIT_DONE, then a normal run with busy length 2
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      i_run_busy = 1'b1;
      repeat (2) tick();
      check("t5_pre_busy", o_busy, 1);
      #2 reset_n = 1'b0;
      #1;
      check("t5_rst_busy",    o_busy,    0);
      check("t5_rst_req",     o_run_req, 0);
      check("t5_rst_done",    o_done,    0);
      check("t5_rst_timeout", o_timeout, 0);
      check("t5_rst_cycles",  o_cycles,  0);
      i_run_busy = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      check("t5_idle", o_busy, 0);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("t5_req", o_run_req, 1);
      tick();
      i_run_busy = 1'b1;
      repeat (2) tick();
      i_run_busy = 1'b0;
      wait_done(10, n_wait);
      check("t5_latency", n_wait,   1);
      check("t5_cycles",  o_cycles, 4);
      tick();

      // 6: busy held 20 cycles; 4-bit counter saturates
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      i_run_busy = 1'b1;
      repeat (20) tick();
      i_run_busy = 1'b0;
      wait_done(10, n_wait);
      check("t6_done4",    r4_done,    1);
      check("t6_cycles",   o_cycles,   22);
      check("t6_cycles4",  r4_cycles,  15);
      check("t6_timeout4", r4_timeout, 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
